// File: rtl/multicycle_control_unit_if.sv
// Control bus between the multicycle control FSM and the datapath it steers.
// master = control unit (consumes IR fields, drives mux selects/enables), slave = datapath.
interface multicycle_control_unit_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       equal;
    logic       pc_write;
    logic       iord;
    logic       ir_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       link;
    logic [1:0] hilo_sel;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [3:0] alu_control;
    logic [1:0] pc_src;
    logic       md_start;
    logic       hilo_write;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  op, funct, equal,
        output pc_write, iord, ir_write, mem_write, mem_to_reg, link, hilo_sel,
               reg_dst, reg_write, alu_src_a, alu_src_b, ext_zero, alu_control,
               pc_src, md_start, hilo_write, illegal, state
    );

    modport slave (
        output op, funct, equal,
        input  pc_write, iord, ir_write, mem_write, mem_to_reg, link, hilo_sel,
               reg_dst, reg_write, alu_src_a, alu_src_b, ext_zero, alu_control,
               pc_src, md_start, hilo_write, illegal, state
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Moore control FSM for the multicycle MIPS datapath; outputs decode state (+IR fields) combinationally.
// Define MULDIV_EN to build the MULT/DIV wait state and MFHI/MFLO writeback.
module multicycle_control_unit #(
    parameter int MULDIV_LAT = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    multicycle_control_unit_if.master        bus
);
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,  S_MEMWR  = 4'd5,  S_RTEX   = 4'd6,  S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,  S_IMMEX  = 4'd9,  S_IMMWB  = 4'd10, S_JUMP    = 4'd11,
        S_JAL     = 4'd12, S_JR     = 4'd13, S_MDWAIT = 4'd14, S_ILLEGAL = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J    = 6'b000010, OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100, OP_BNE  = 6'b000101, OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010, OP_ANDI = 6'b001100, OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011, OP_SW   = 6'b101011;
    localparam logic [5:0] F_SLL = 6'b000000, F_SRL = 6'b000010, F_SRA = 6'b000011, F_JR = 6'b001000;
    localparam logic [5:0] F_MFHI = 6'b010000, F_MFLO = 6'b010010;

    state_t     state_reg;
    state_t     decode_next;
    logic       funct_known;
    logic [3:0] rtype_alu;
    logic       is_shift;
    logic       is_md;
    logic       is_mfhi;
    logic       is_mflo;

    // R-type ALU operation; unknown functs fall through to the illegal trap.
    always_comb begin
        funct_known = 1'b1;
        rtype_alu   = 4'd2;
        case (bus.funct)
            F_SLL:     rtype_alu = 4'd3;
            F_SRL:     rtype_alu = 4'd8;
            F_SRA:     rtype_alu = 4'd9;
            6'b100000,
            6'b100001: rtype_alu = 4'd2;
            6'b100010,
            6'b100011: rtype_alu = 4'd6;
            6'b100100: rtype_alu = 4'd0;
            6'b100101: rtype_alu = 4'd1;
            6'b101010: rtype_alu = 4'd7;
            default:   funct_known = 1'b0;
        endcase
    end

    assign is_shift = (bus.funct == F_SLL) || (bus.funct == F_SRL) || (bus.funct == F_SRA);

`ifdef MULDIV_EN
    localparam logic [3:0] LAT_M1 = 4'(MULDIV_LAT - 1);
    logic [3:0] count_reg;
    assign is_md   = (bus.funct[5:2] == 4'b0110);
    assign is_mfhi = (bus.funct == F_MFHI);
    assign is_mflo = (bus.funct == F_MFLO);
`else
    assign is_md   = 1'b0;
    assign is_mfhi = 1'b0;
    assign is_mflo = 1'b0;
`endif

    always_comb begin
        decode_next = S_ILLEGAL;
        case (bus.op)
            OP_LW, OP_SW:                      decode_next = S_MEMADR;
            OP_BEQ, OP_BNE:                    decode_next = S_BRANCH;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: decode_next = S_IMMEX;
            OP_J:                              decode_next = S_JUMP;
            OP_JAL:                            decode_next = S_JAL;
            OP_RTYPE: begin
                if (bus.funct == F_JR)         decode_next = S_JR;
                else if (is_mfhi || is_mflo)   decode_next = S_ALUWB;
                else if (is_md)                decode_next = S_MDWAIT;
                else if (funct_known)          decode_next = S_RTEX;
                else                           decode_next = S_ILLEGAL;
            end
            default:                           decode_next = S_ILLEGAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
`ifdef MULDIV_EN
            count_reg <= '0;
`endif
        end else begin
            case (state_reg)
                S_FETCH:   state_reg <= S_DECODE;
                S_DECODE: begin
                    state_reg <= decode_next;
`ifdef MULDIV_EN
                    if (decode_next == S_MDWAIT) count_reg <= LAT_M1;
`endif
                end
                S_MEMADR:  state_reg <= (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:   state_reg <= S_MEMWB;
                S_RTEX:    state_reg <= S_ALUWB;
                S_IMMEX:   state_reg <= S_IMMWB;
                S_ILLEGAL: state_reg <= S_ILLEGAL;
`ifdef MULDIV_EN
                S_MDWAIT: begin
                    if (count_reg == 4'd0) state_reg <= S_FETCH;
                    else                   count_reg <= count_reg - 4'd1;
                end
`endif
                default:   state_reg <= S_FETCH;
            endcase
        end
    end

    assign bus.state = rst_n ? state_reg : S_FETCH;

    // Outputs are a pure function of state and IR fields, held at zero while in reset.
    always_comb begin
        bus.pc_write    = 1'b0;
        bus.iord        = 1'b0;
        bus.ir_write    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_to_reg  = 1'b0;
        bus.link        = 1'b0;
        bus.hilo_sel    = 2'b00;
        bus.reg_dst     = 2'b00;
        bus.reg_write   = 1'b0;
        bus.alu_src_a   = 2'b00;
        bus.alu_src_b   = 2'b00;
        bus.ext_zero    = 1'b0;
        bus.alu_control = 4'd0;
        bus.pc_src      = 2'b00;
        bus.md_start    = 1'b0;
        bus.hilo_write  = 1'b0;
        bus.illegal     = 1'b0;
        if (rst_n) begin
            case (state_reg)
                S_FETCH: begin
                    bus.ir_write = 1'b1; bus.pc_write = 1'b1;
                    bus.alu_src_b = 2'b01; bus.alu_control = 4'd2;
                end
                S_DECODE: begin
                    bus.alu_src_b = 2'b11; bus.alu_control = 4'd2;
                end
                S_MEMADR: begin
                    bus.alu_src_a = 2'b01; bus.alu_src_b = 2'b10; bus.alu_control = 4'd2;
                end
                S_MEMRD:  bus.iord = 1'b1;
                S_MEMWB: begin
                    bus.mem_to_reg = 1'b1; bus.reg_write = 1'b1;
                end
                S_MEMWR: begin
                    bus.iord = 1'b1; bus.mem_write = 1'b1;
                end
                S_RTEX: begin
                    bus.alu_src_a   = is_shift ? 2'b10 : 2'b01;
                    bus.alu_control = rtype_alu;
                end
                S_ALUWB: begin
                    bus.reg_write = 1'b1; bus.reg_dst = 2'b01;
                    bus.hilo_sel  = is_mflo ? 2'b01 : (is_mfhi ? 2'b10 : 2'b00);
                end
                S_BRANCH: begin
                    bus.alu_src_a = 2'b01; bus.alu_control = 4'd6; bus.pc_src = 2'b01;
                    bus.pc_write  = ((bus.op == OP_BEQ) && bus.equal) ||
                                    ((bus.op == OP_BNE) && !bus.equal);
                end
                S_IMMEX: begin
                    bus.alu_src_a = 2'b01; bus.alu_src_b = 2'b10;
                    bus.ext_zero  = (bus.op == OP_ANDI) || (bus.op == OP_ORI);
                    case (bus.op)
                        OP_SLTI: bus.alu_control = 4'd7;
                        OP_ANDI: bus.alu_control = 4'd0;
                        OP_ORI:  bus.alu_control = 4'd1;
                        default: bus.alu_control = 4'd2;
                    endcase
                end
                S_IMMWB: begin
                    bus.reg_write = 1'b1;
                    bus.ext_zero  = (bus.op == OP_ANDI) || (bus.op == OP_ORI);
                end
                S_JUMP: begin
                    bus.pc_src = 2'b10; bus.pc_write = 1'b1;
                end
                S_JAL: begin
                    bus.pc_src = 2'b10; bus.pc_write = 1'b1;
                    bus.reg_write = 1'b1; bus.reg_dst = 2'b10; bus.link = 1'b1;
                end
                S_JR: begin
                    bus.pc_src = 2'b11; bus.pc_write = 1'b1;
                end
`ifdef MULDIV_EN
                S_MDWAIT: begin
                    bus.md_start   = (count_reg == LAT_M1);
                    bus.hilo_write = (count_reg == 4'd0);
                end
`endif
                S_ILLEGAL: bus.illegal = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: expected output vectors go through a scoreboard queue.
// MULT/MFLO checks follow the MULDIV_EN build; without it those functs must trap.
module tb_multicycle_control_unit;
    typedef struct packed {
        logic [3:0] state;
        logic       pc_write;
        logic       iord;
        logic       ir_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic       link;
        logic [1:0] hilo_sel;
        logic [1:0] reg_dst;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [3:0] alu_control;
        logic [1:0] pc_src;
        logic       md_start;
        logic       hilo_write;
        logic       illegal;
    } out_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   passes;
    int   fails;
    out_t exp_q[$];
    string tag_q[$];

    multicycle_control_unit_if bus ();

    multicycle_control_unit #(.MULDIV_LAT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t sample();
        out_t o;
        o.state = bus.state;           o.pc_write = bus.pc_write;
        o.iord = bus.iord;             o.ir_write = bus.ir_write;
        o.mem_write = bus.mem_write;   o.mem_to_reg = bus.mem_to_reg;
        o.link = bus.link;             o.hilo_sel = bus.hilo_sel;
        o.reg_dst = bus.reg_dst;       o.reg_write = bus.reg_write;
        o.alu_src_a = bus.alu_src_a;   o.alu_src_b = bus.alu_src_b;
        o.ext_zero = bus.ext_zero;     o.alu_control = bus.alu_control;
        o.pc_src = bus.pc_src;         o.md_start = bus.md_start;
        o.hilo_write = bus.hilo_write; o.illegal = bus.illegal;
        return o;
    endfunction

    function automatic out_t st(input logic [3:0] s);
        out_t o;
        o = '0;
        o.state = s;
        return o;
    endfunction

    function automatic out_t fetch_exp();
        out_t o;
        o = st(4'd0);
        o.ir_write = 1'b1; o.pc_write = 1'b1; o.alu_src_b = 2'b01; o.alu_control = 4'd2;
        return o;
    endfunction

    function automatic out_t decode_exp();
        out_t o;
        o = st(4'd1);
        o.alu_src_b = 2'b11; o.alu_control = 4'd2;
        return o;
    endfunction

    // Push expectation, compare at the falling edge, then advance to just after the next rising edge.
    task automatic step(input string tag, input out_t e);
        out_t got;
        out_t want;
        string t;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        got  = sample();
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        checks++;
        assert (got === want) begin
            passes++;
            $display("%-14s state=%0d vec=%h ok", t, got.state, got);
        end else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", t, got, want);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [5:0] op, input logic [5:0] funct, input logic eq);
        bus.op = op; bus.funct = funct; bus.equal = eq;
    endtask

    task automatic branch_instr(input string tag, input logic [5:0] op, input logic eq,
                                input logic taken);
        out_t e;
        set_ir(op, 6'd0, eq);
        step({tag, "_f"}, fetch_exp());
        step({tag, "_d"}, decode_exp());
        e = st(4'd8); e.alu_src_a = 2'b01; e.alu_control = 4'd6; e.pc_src = 2'b01;
        e.pc_write = taken;
        step({tag, "_br"}, e);
    endtask

    task automatic rtype_instr(input string tag, input logic [5:0] funct,
                               input logic [1:0] src_a, input logic [3:0] alu);
        out_t e;
        set_ir(6'd0, funct, 1'b0);
        step({tag, "_f"}, fetch_exp());
        step({tag, "_d"}, decode_exp());
        e = st(4'd6); e.alu_src_a = src_a; e.alu_control = alu;
        step({tag, "_ex"}, e);
        e = st(4'd7); e.reg_write = 1'b1; e.reg_dst = 2'b01;
        step({tag, "_wb"}, e);
    endtask

    task automatic imm_instr(input string tag, input logic [5:0] op, input logic [3:0] alu,
                             input logic zx);
        out_t e;
        set_ir(op, 6'b111111, 1'b0);
        step({tag, "_f"}, fetch_exp());
        step({tag, "_d"}, decode_exp());
        e = st(4'd9); e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.alu_control = alu;
        e.ext_zero = zx;
        step({tag, "_ex"}, e);
        e = st(4'd10); e.reg_write = 1'b1; e.ext_zero = zx;
        step({tag, "_wb"}, e);
    endtask

    initial begin
        out_t e;
        checks = 0; passes = 0; fails = 0;
        rst_n = 1'b0;
        set_ir(6'b100011, 6'b000011, 1'b1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step("reset", st(4'd0));
        rst_n = 1'b1;

        // LW: five cycles
        set_ir(6'b100011, 6'd0, 1'b0);
        step("lw_f", fetch_exp());
        step("lw_d", decode_exp());
        e = st(4'd2); e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.alu_control = 4'd2;
        step("lw_adr", e);
        e = st(4'd3); e.iord = 1'b1;
        step("lw_rd", e);
        e = st(4'd4); e.mem_to_reg = 1'b1; e.reg_write = 1'b1;
        step("lw_wb", e);

        // SW: four cycles
        set_ir(6'b101011, 6'd0, 1'b0);
        step("sw_f", fetch_exp());
        step("sw_d", decode_exp());
        e = st(4'd2); e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.alu_control = 4'd2;
        step("sw_adr", e);
        e = st(4'd5); e.iord = 1'b1; e.mem_write = 1'b1;
        step("sw_wr", e);

        branch_instr("bne_eq", 6'b000101, 1'b1, 1'b0);
        branch_instr("bne_ne", 6'b000101, 1'b0, 1'b1);
        branch_instr("beq_eq", 6'b000100, 1'b1, 1'b1);
        branch_instr("beq_ne", 6'b000100, 1'b0, 1'b0);

        rtype_instr("sra", 6'b000011, 2'b10, 4'd9);
        rtype_instr("sll", 6'b000000, 2'b10, 4'd3);
        rtype_instr("add", 6'b100000, 2'b01, 4'd2);
        rtype_instr("subu", 6'b100011, 2'b01, 4'd6);
        rtype_instr("slt", 6'b101010, 2'b01, 4'd7);

        imm_instr("andi", 6'b001100, 4'd0, 1'b1);
        imm_instr("ori", 6'b001101, 4'd1, 1'b1);
        imm_instr("slti", 6'b001010, 4'd7, 1'b0);
        imm_instr("addi", 6'b001000, 4'd2, 1'b0);

        set_ir(6'b000011, 6'd0, 1'b0);
        step("jal_f", fetch_exp());
        step("jal_d", decode_exp());
        e = st(4'd12); e.pc_src = 2'b10; e.pc_write = 1'b1; e.reg_write = 1'b1;
        e.reg_dst = 2'b10; e.link = 1'b1;
        step("jal_x", e);

        set_ir(6'b000010, 6'd0, 1'b0);
        step("j_f", fetch_exp());
        step("j_d", decode_exp());
        e = st(4'd11); e.pc_src = 2'b10; e.pc_write = 1'b1;
        step("j_x", e);

        set_ir(6'b000000, 6'b001000, 1'b0);
        step("jr_f", fetch_exp());
        step("jr_d", decode_exp());
        e = st(4'd13); e.pc_src = 2'b11; e.pc_write = 1'b1;
        step("jr_x", e);

`ifdef MULDIV_EN
        // MULT: exactly four wait cycles, start first, HI/LO capture last
        set_ir(6'b000000, 6'b011000, 1'b0);
        step("mult_f", fetch_exp());
        step("mult_d", decode_exp());
        for (int i = 0; i < 4; i++) begin
            e = st(4'd14);
            e.md_start   = (i == 0);
            e.hilo_write = (i == 3);
            step("mult_wait", e);
        end
        set_ir(6'b000000, 6'b010010, 1'b0);
        step("mflo_f", fetch_exp());
        step("mflo_d", decode_exp());
        e = st(4'd7); e.reg_write = 1'b1; e.reg_dst = 2'b01; e.hilo_sel = 2'b01;
        step("mflo_wb", e);
        set_ir(6'b000000, 6'b010000, 1'b0);
        step("mfhi_f", fetch_exp());
        step("mfhi_d", decode_exp());
        e = st(4'd7); e.reg_write = 1'b1; e.reg_dst = 2'b01; e.hilo_sel = 2'b10;
        step("mfhi_wb", e);
        // Reset mid-count aborts with no pulses
        set_ir(6'b000000, 6'b011010, 1'b0);
        step("div_f", fetch_exp());
        step("div_d", decode_exp());
        e = st(4'd14); e.md_start = 1'b1;
        step("div_wait", e);
        step("div_wait", st(4'd14));
        rst_n = 1'b0;
        step("div_abort", st(4'd0));
        rst_n = 1'b1;
        set_ir(6'b000010, 6'd0, 1'b0);
        step("abort_f", fetch_exp());
        step("abort_d", decode_exp());
        e = st(4'd11); e.pc_src = 2'b10; e.pc_write = 1'b1;
        step("abort_j", e);
`else
        // Without the mul/div unit MULT traps; recover through reset
        set_ir(6'b000000, 6'b011000, 1'b0);
        step("mult_f", fetch_exp());
        step("mult_d", decode_exp());
        e = st(4'd15); e.illegal = 1'b1;
        step("mult_ill", e);
        step("mult_ill", e);
        rst_n = 1'b0;
        step("mult_rst", st(4'd0));
        rst_n = 1'b1;
`endif

        // Unknown opcode traps and stays trapped until reset
        set_ir(6'b111111, 6'd0, 1'b0);
        step("ill_f", fetch_exp());
        step("ill_d", decode_exp());
        for (int i = 0; i < 10; i++) begin
            e = st(4'd15); e.illegal = 1'b1;
            if (i == 5) set_ir(6'b000010, 6'd0, 1'b1);
            step("ill_hold", e);
        end
        rst_n = 1'b0;
        step("ill_rst", st(4'd0));
        rst_n = 1'b1;
        step("post_rst_f", fetch_exp());
        step("post_rst_d", decode_exp());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
